// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared pipeline package for the MEM/WB stage boundary.
// Holds the skid-buffer state encoding, the PC increment constant and the
// default datapath widths used by the stage registers.
package mem_wb_skid_reg_pkg;

  // Default widths for the MEM/WB payload
  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDestW = 4;
  localparam int unsigned DefPcW   = 32;

  // Byte distance to the next sequential instruction
  localparam int unsigned PcIncr = 4;

  // Occupancy of the two-entry skid buffer:
  //   StOne  - main slot valid
  //   StFull - main and skid slots valid
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/mem_wb_skid_reg_pipe_slot.sv
// Single payload register with load enable (one slot of the skid buffer).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset, clears the payload to 0
//   load - capture d on the next rising edge
//   d    - payload to capture
//   q    - held payload
module mem_wb_skid_reg_pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register built as a two-entry skid buffer.
// The main slot drives the WB-side outputs; the skid slot absorbs one extra
// entry so in_ready can come from a register and never depends on out_ready.
// Ports:
//   clk, rst, clr            - clock, sync active-low reset, sync flush
//   in_valid / in_ready      - MEM-side handshake
//   *_in                     - MEM-side payload
//   out_valid / out_ready    - WB-side handshake
//   *_out                    - held payload, pc_out + 4 and the write-back data mux
module mem_wb_skid_reg
  import mem_wb_skid_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEST_W = DefDestW,
  parameter int unsigned PC_W   = DefPcW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_enable_in,
  input  logic              mem_read_enable_in,
  input  logic [WIDTH-1:0]  alu_res_in,
  input  logic [WIDTH-1:0]  data_memory_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_enable_out,
  output logic              mem_read_enable_out,
  output logic [WIDTH-1:0]  alu_res_out,
  output logic [WIDTH-1:0]  data_memory_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_plus4_out,
  output logic [WIDTH-1:0]  wb_data_out
);

  localparam int unsigned PayW = 2 + 2 * WIDTH + DEST_W + PC_W;

  skid_state_e     state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            accept, pop;
  logic            load_main, load_skid, main_from_skid;
  logic [PayW-1:0] in_pay, main_d, main_q, skid_q;
  logic            main_wb_enable;

  assign in_pay = {wb_enable_in, mem_read_enable_in, alu_res_in, data_memory_in, dest_in, pc_in};

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (clr) begin
      // Flush wins over the handshake: any offered entry is dropped
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Registered ready: high next cycle whenever there will be a free slot
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pay;

  mem_wb_skid_reg_pipe_slot #(
    .W(PayW)
  ) u_main_slot (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (main_q)
  );

  mem_wb_skid_reg_pipe_slot #(
    .W(PayW)
  ) u_skid_slot (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_pay),
    .q    (skid_q)
  );

  assign {main_wb_enable, mem_read_enable_out, alu_res_out, data_memory_out, dest_out, pc_out} =
      main_q;

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != StEmpty);
  assign wb_enable_out = main_wb_enable && out_valid;
  assign pc_plus4_out  = pc_out + PC_W'(PcIncr);
  assign wb_data_out   = mem_read_enable_out ? data_memory_out : alu_res_out;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mem_wb_skid_reg;

  typedef struct {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] dat;
    logic [3:0]  dest;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic        wb_enable_in, mem_read_enable_in, wb_enable_out, mem_read_enable_out;
  logic [31:0] alu_res_in, data_memory_in, pc_in;
  logic [31:0] alu_res_out, data_memory_out, pc_out, pc_plus4_out, wb_data_out;
  logic [3:0]  dest_in, dest_out;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: FIFO of accepted entries, capacity two
  ent_t model_q[$];

  always #5 clk = ~clk;

  mem_wb_skid_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .clr                 (clr),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .wb_enable_in        (wb_enable_in),
    .mem_read_enable_in  (mem_read_enable_in),
    .alu_res_in          (alu_res_in),
    .data_memory_in      (data_memory_in),
    .dest_in             (dest_in),
    .pc_in               (pc_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .wb_enable_out       (wb_enable_out),
    .mem_read_enable_out (mem_read_enable_out),
    .alu_res_out         (alu_res_out),
    .data_memory_out     (data_memory_out),
    .dest_out            (dest_out),
    .pc_out              (pc_out),
    .pc_plus4_out        (pc_plus4_out),
    .wb_data_out         (wb_data_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.wb   = 1'($urandom);
    e.mr   = 1'($urandom);
    e.alu  = $urandom;
    e.dat  = $urandom;
    e.dest = 4'($urandom);
    e.pc   = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    return e;
  endfunction

  function automatic ent_t mk_ent(input logic mr, input logic [31:0] alu, input logic [31:0] dat,
                                  input logic [31:0] pc);
    ent_t e;
    e.wb   = 1'b1;
    e.mr   = mr;
    e.alu  = alu;
    e.dat  = dat;
    e.dest = pc[5:2];
    e.pc   = pc;
    return e;
  endfunction

  task automatic compare_outputs();
    logic [31:0] exp_pc4;
    check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      exp_pc4 = model_q[0].pc + 32'd4;
      check("pc_out", 64'(pc_out), 64'(model_q[0].pc));
      check("pc_plus4_out", 64'(pc_plus4_out), 64'(exp_pc4));
      check("alu_res_out", 64'(alu_res_out), 64'(model_q[0].alu));
      check("data_memory_out", 64'(data_memory_out), 64'(model_q[0].dat));
      check("dest_out", 64'(dest_out), 64'(model_q[0].dest));
      check("mem_read_enable_out", 64'(mem_read_enable_out), 64'(model_q[0].mr));
      check("wb_enable_out", 64'(wb_enable_out), 64'(model_q[0].wb));
      check("wb_data_out", 64'(wb_data_out),
            64'(model_q[0].mr ? model_q[0].dat : model_q[0].alu));
    end else begin
      check("wb_enable_out_idle", 64'(wb_enable_out), 64'(0));
    end
  endtask

  task automatic check_reset_zero();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_pc_out", 64'(pc_out), 64'(0));
    check("rst_pc_plus4", 64'(pc_plus4_out), 64'(4));
    check("rst_alu", 64'(alu_res_out), 64'(0));
    check("rst_dmem", 64'(data_memory_out), 64'(0));
    check("rst_dest", 64'(dest_out), 64'(0));
    check("rst_wb_data", 64'(wb_data_out), 64'(0));
    check("rst_wb_enable", 64'(wb_enable_out), 64'(0));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // compare the DUT against the model on the falling edge.
  task automatic cycle(input logic iv, input logic ordy, input logic c, input logic r,
                       input ent_t e);
    logic acc;
    rst                = r;
    clr                = c;
    in_valid           = iv;
    out_ready          = ordy;
    wb_enable_in       = e.wb;
    mem_read_enable_in = e.mr;
    alu_res_in         = e.alu;
    data_memory_in     = e.dat;
    dest_in            = e.dest;
    pc_in              = e.pc;
    @(posedge clk);
    acc = iv && (model_q.size() < 2);
    if (!r || c) begin
      model_q.delete();
    end else begin
      if (ordy && model_q.size() > 0) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    ent_t e;
    e = rand_ent();
    @(negedge clk);

    // Reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, e);
    check_reset_zero();

    // Passthrough with no bubbles
    cycle(1'b1, 1'b1, 1'b0, 1'b1, mk_ent(1'b0, 32'h1, 32'h2, 32'h100));
    check("pass_pc0", 64'(pc_out), 64'(32'h100));
    cycle(1'b1, 1'b1, 1'b0, 1'b1, mk_ent(1'b0, 32'h3, 32'h4, 32'h104));
    check("pass_pc4_1", 64'(pc_plus4_out), 64'(32'h108));
    cycle(1'b1, 1'b1, 1'b0, 1'b1, mk_ent(1'b0, 32'h5, 32'h6, 32'h108));
    check("pass_pc4_2", 64'(pc_plus4_out), 64'(32'h10C));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // Backpressure: A, B fill the buffer, C is held off, then drain in order
    cycle(1'b1, 1'b0, 1'b0, 1'b1, mk_ent(1'b0, 32'hA, 32'h0, 32'h200));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, mk_ent(1'b0, 32'hB, 32'h0, 32'h204));
    check("bp_full_in_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, mk_ent(1'b0, 32'hC, 32'h0, 32'h208));
    check("bp_hold_head", 64'(alu_res_out), 64'(32'hA));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, e);
    check("bp_second", 64'(alu_res_out), 64'(32'hB));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // Write-back mux
    cycle(1'b1, 1'b0, 1'b0, 1'b1, mk_ent(1'b1, 32'hBEEF, 32'hDEAD, 32'h300));
    check("wbmux_mem", 64'(wb_data_out), 64'(32'hDEAD));
    cycle(1'b1, 1'b1, 1'b0, 1'b1, mk_ent(1'b0, 32'hBEEF, 32'hDEAD, 32'h304));
    check("wbmux_alu", 64'(wb_data_out), 64'(32'hBEEF));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // Flush while FULL with a concurrent offer
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_ent());
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_ent());
    cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_ent());
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // Reset while FULL
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_ent());
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_ent());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_ent());
    check_reset_zero();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // PC wrap
    cycle(1'b1, 1'b0, 1'b0, 1'b1, mk_ent(1'b0, 32'h7, 32'h8, 32'hFFFF_FFFC));
    check("pc_wrap", 64'(pc_plus4_out), 64'(32'h0000_0000));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, e);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) != 0), rand_ent());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
MEM_WB_SKID_REG -- requirements
Module: mem_wb_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: ALU result and memory data width.
REQ-002 SHALL have parameter DEST_W, default 4: destination register index width.
REQ-003 SHALL have parameter PC_W, default 32: program counter width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous flush of all held entries.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): MEM-side handshake.
REQ-008 SHALL have inputs wb_enable_in (1), mem_read_enable_in (1), alu_res_in (WIDTH), data_memory_in (WIDTH), dest_in (DEST_W), pc_in (PC_W).
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): WB-side handshake.
REQ-010 SHALL have outputs wb_enable_out (1), mem_read_enable_out (1), alu_res_out (WIDTH), data_memory_out (WIDTH), dest_out (DEST_W), pc_out (PC_W), pc_plus4_out (PC_W), wb_data_out (WIDTH).

Function
REQ-011 SHALL hold entries in a 2-entry skid buffer: main slot (drives outputs) and skid slot.
REQ-012 SHALL use a state machine with states EMPTY, ONE and FULL, where ONE means main valid and FULL means main and skid valid.
REQ-013 SHALL accept an input when in_valid && in_ready and pop an output when out_valid && out_ready.
REQ-014 SHALL drive in_ready from a register, asserted exactly when the state is not FULL; no combinational path from out_ready to in_ready.
REQ-015 SHALL drive out_valid high exactly in states ONE and FULL.
REQ-016 In state EMPTY, an accept SHALL load main and move to ONE; latency is 1 cycle from accept to out_valid.
REQ-017 In state ONE, a simultaneous accept and pop SHALL load main and stay in ONE; an accept alone SHALL load skid and move to FULL; a pop alone SHALL move to EMPTY.
REQ-018 In state FULL, a pop SHALL move skid into main and go to ONE; no accept is possible in FULL.
REQ-019 SHALL preserve entry order, with no loss or duplication under any out_ready pattern.
REQ-020 SHALL hold pc_plus4_out equal to pc_out + 4, computed modulo 2^PC_W and wrapping at the top of the range.
REQ-021 SHALL drive wb_data_out = mem_read_enable_out ? data_memory_out : alu_res_out.
REQ-022 SHALL gate wb_enable_out with out_valid, so it is 0 whenever out_valid is 0.
REQ-023 SHALL apply clr as follows: state goes to EMPTY, in_ready goes to 1, and an input offered in the same cycle is discarded.
REQ-024 SHALL give priority rst > clr > handshake.
REQ-025 SHALL leave payload registers unchanged when no slot is loaded.

Reset
REQ-026 SHALL, while rst=0 at a clk edge, set state EMPTY, out_valid 0 and in_ready 1.
REQ-027 SHALL, while rst=0 at a clk edge, set all payload outputs to 0, including pc_out, alu_res_out, data_memory_out and dest_out; pc_plus4_out then reads 4.
REQ-028 SHALL, when reset is asserted mid-transfer in any state, discard held entries and produce no output pulse after release.

Structure
REQ-029 SHALL take its state encoding enumeration and the PC increment constant (4) from the shared pipeline package.
REQ-030 SHALL take the default widths WIDTH, DEST_W and PC_W from that same package.
REQ-031 SHALL use one natural sub-module, pipe_slot: a single payload register with load enable, instantiated twice.

Verification
REQ-032 SHALL cover passthrough: out_ready=1 and in_valid every cycle with pc_in 0x100, 0x104, 0x108 -> pc_out tracks with 1-cycle latency, pc_plus4_out 0x104, 0x108, 0x10C, no bubbles.
REQ-033 SHALL cover backpressure: out_ready=0, push A then B -> FULL, in_ready=0; third push is held off; release out_ready -> A then B emitted in order.
REQ-034 SHALL cover write-back mux: mem_read_enable_in=1, data_memory_in=0xDEAD, alu_res_in=0xBEEF -> wb_data_out=0xDEAD; with mem_read_enable_in=0 -> 0xBEEF.
REQ-035 SHALL cover flush: in FULL, assert clr together with in_valid -> next cycle out_valid=0, wb_enable_out=0, in_ready=1, the offered entry is never emitted.
REQ-036 SHALL cover reset mid-operation: rst=0 in FULL -> all outputs 0, pc_plus4_out=4, state EMPTY; no stale entry appears after release.
REQ-037 SHALL cover PC wrap: pc_in=0xFFFFFFFC -> pc_plus4_out=0x00000000.
